// File: rtl/mux_arb.sv
// Two-channel round-robin merge into a single-entry registered output stage.
// Optional per-channel acceptance counters are enabled by defining MUX_ARB_STATS_EN.
module mux_arb #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x_data,
    input  logic             x_valid,
    output logic             x_ready,
    input  logic [WIDTH-1:0] y_data,
    input  logic             y_valid,
    output logic             y_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    output logic             out_valid,
    input  logic             out_ready
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [15:0]      cnt_x,
    output logic [15:0]      cnt_y
`endif
);

    logic load_en_s;
    logic grant_x_s;
    logic grant_y_s;
    logic last_sel_r;

    assign load_en_s = !out_valid || out_ready;

    // Grant selection; ties go to the channel that was not served last.
    always_comb begin
        grant_x_s = 1'b0;
        grant_y_s = 1'b0;
        if (rst_n && load_en_s) begin
            case ({x_valid, y_valid})
                2'b10:   grant_x_s = 1'b1;
                2'b01:   grant_y_s = 1'b1;
                2'b11: begin
                    grant_x_s = !last_sel_r;
                    grant_y_s = last_sel_r;
                end
                default: begin
                    grant_x_s = 1'b0;
                    grant_y_s = 1'b0;
                end
            endcase
        end else begin
            grant_x_s = 1'b0;
            grant_y_s = 1'b0;
        end
    end

    assign x_ready = grant_x_s;
    assign y_ready = grant_y_s;

    // Output register and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= {WIDTH{1'b0}};
            out_sel    <= 1'b0;
            out_valid  <= 1'b0;
            last_sel_r <= 1'b1;
        end else if (load_en_s) begin
            if (grant_x_s) begin
                out_data   <= x_data;
                out_sel    <= 1'b1;
                out_valid  <= 1'b1;
                last_sel_r <= 1'b1;
            end else if (grant_y_s) begin
                out_data   <= y_data;
                out_sel    <= 1'b0;
                out_valid  <= 1'b1;
                last_sel_r <= 1'b0;
            end else begin
                out_valid  <= 1'b0;
            end
        end else begin
            out_valid <= out_valid;
        end
    end

`ifdef MUX_ARB_STATS_EN
    // Accepted-word counters; 16-bit wrap is intentional.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_x <= 16'h0000;
            cnt_y <= 16'h0000;
        end else begin
            if (grant_x_s) begin
                cnt_x <= cnt_x + 16'h0001;
            end else begin
                cnt_x <= cnt_x;
            end
            if (grant_y_s) begin
                cnt_y <= cnt_y + 16'h0001;
            end else begin
                cnt_y <= cnt_y;
            end
        end
    end
`endif

endmodule
